lane_invert_pipe: RTL and testbench

Parametrised, pipelined per-lane inverter array. Each of `WIDTH` lanes is built by a generate loop. A programmable invert mask selects which lanes are complemented and which pass through unchanged. Data moves through `DEPTH` registered stages under a valid/ready handshake, with full backpressure and a transfer counter. The block sits between a producer and a consumer as a drop-in, flow-controlled generalisation of the fixed 8-lane combinational inverter buffer.

---
 rtl/lane_invert_pipe.sv | 98 +++++++++
 tb/tb_lane_invert_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_invert_pipe.sv
// Flow-controlled, DEPTH-stage pipeline that XORs each incoming word with a
// programmable per-lane invert mask, with a wrapping output-transfer counter.
module lane_invert_pipe #(
  parameter int                WIDTH    = 8,
  parameter int                DEPTH    = 2,
  parameter int                CNT_W    = 16,
  parameter logic [WIDTH-1:0]  MASK_RST = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mask,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [DEPTH-1:0]            v_q, v_d, src_v, rdy;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d, src_d;
  logic [WIDTH-1:0]            mask_q, mask_d, masked;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        rdy_chain;
  logic                        out_xfer;

  genvar gi;

  for (gi = 0; gi < WIDTH; gi++) begin : g_lane
    assign masked[gi] = in_data[gi] ^ mask_q[gi];
  end

  // Stage 0 is fed from the masked input; later stages copy their predecessor.
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign src_v[gi] = in_valid;
      assign src_d[gi] = masked;
    end else begin : g_rest
      assign src_v[gi] = v_q[gi-1];
      assign src_d[gi] = d_q[gi-1];
    end
  end

  // Ready ripples back from the consumer; any empty stage opens the chain.
  always_comb begin
    rdy_chain = out_ready;
    rdy       = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy_chain = !v_q[k] || rdy_chain;
      rdy[k]    = rdy_chain;
    end
  end

  assign out_xfer = v_q[DEPTH-1] && out_ready;

  always_comb begin
    v_d    = v_q;
    d_d    = d_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (rdy[k]) begin
        v_d[k] = src_v[k];
        d_d[k] = src_d[k];
      end
    end
    if (mask_we) begin
      mask_d = mask_in;
    end
    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= '0;
      d_q    <= '0;
      mask_q <= MASK_RST;
      cnt_q  <= '0;
    end else begin
      v_q    <= v_d;
      d_q    <= d_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign mask      = mask_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_lane_invert_pipe.sv
// Self-checking bench for lane_invert_pipe: directed scenarios plus a random
// stream scored against a queue-based model of an in-order, fixed-latency pipe.
module tb_lane_invert_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             mask_we;
  logic [WIDTH-1:0] mask_in;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] out_data, mask;
  logic [15:0]      xfer_cnt;
  logic             s_in_ready, s_out_valid;
  logic [WIDTH-1:0] s_out_data, s_mask;
  logic [3:0]       s_xfer_cnt;

  lane_invert_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .mask_we(mask_we), .mask_in(mask_in),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mask(mask), .xfer_cnt(xfer_cnt)
  );

  lane_invert_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .mask_we(mask_we), .mask_in(mask_in),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready),
    .mask(s_mask), .xfer_cnt(s_xfer_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: accepted words wait in a queue with their accept edge.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               t;
  } ent_t;

  ent_t             q[$];
  int               cyc;
  logic [WIDTH-1:0] mask_m;
  int               cnt_m;
  int               n_cmp = 0;
  int               n_fail = 0;

  function automatic bit exp_ir();
    return (q.size() < DEPTH) || out_ready;
  endfunction

  function automatic bit exp_ov();
    return (q.size() > 0) && ((cyc - q[0].t) >= DEPTH - 1);
  endfunction

  task automatic drive(input bit iv, input logic [WIDTH-1:0] id, input bit ordy,
                       input bit mwe, input logic [WIDTH-1:0] min);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    mask_we   = mwe;
    mask_in   = min;
    #1;
  endtask

  // Advance one clock edge and update the model from the pre-edge inputs.
  task automatic tick();
    bit acc, xf;
    acc = in_valid && exp_ir();
    xf  = exp_ov() && out_ready;
    @(posedge clk);
    cyc++;
    if (reset) begin
      q.delete();
      cnt_m  = 0;
      mask_m = '1;
    end else begin
      if (xf) begin
        $display("xfer #%0d data=%h", cnt_m, q[0].d);
        void'(q.pop_front());
        cnt_m++;
      end
      if (acc) q.push_back('{d: in_data ^ mask_m, t: cyc});
      if (mask_we) mask_m = mask_in;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 8'h00, 1, 0, 8'h00);
    tick();
    tick();
    reset = 1'b0;
    drive(0, 8'h00, 1, 0, 8'h00);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (mask !== 8'hFF) begin n_fail++; $display("FAIL rst_mask got=%h exp=ff", mask); end
    n_cmp++; if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_xfer_cnt got=%0d exp=0", xfer_cnt); end
    n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
  endtask

  task automatic test_default_mask();
    drive(1, 8'hAA, 1, 0, 8'h00);
    tick();
    drive(1, 8'h0F, 1, 0, 8'h00);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dflt_early_valid got=%b exp=0", out_valid); end
    tick();
    drive(0, 8'h00, 1, 0, 8'h00);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin n_fail++; $display("FAIL dflt_word0 got=%b/%h exp=1/55", out_valid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hF0) begin n_fail++; $display("FAIL dflt_word1 got=%b/%h exp=1/f0", out_valid, out_data); end
    tick();
    n_cmp++; if (xfer_cnt !== 16'd2) begin n_fail++; $display("FAIL dflt_xfer_cnt got=%0d exp=2", xfer_cnt); end
  endtask

  task automatic test_mask_write();
    drive(0, 8'h00, 1, 1, 8'h0F);
    tick();
    n_cmp++; if (mask !== 8'h0F) begin n_fail++; $display("FAIL mw_mask got=%h exp=0f", mask); end
    drive(1, 8'hAA, 1, 0, 8'h00);
    tick();
    drive(0, 8'h00, 1, 1, 8'h00);
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_fail++; $display("FAIL mw_0f got=%b/%h exp=1/a5", out_valid, out_data); end
    drive(1, 8'h3C, 1, 0, 8'h00);
    tick();
    drive(0, 8'h00, 1, 0, 8'h00);
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin n_fail++; $display("FAIL mw_00 got=%b/%h exp=1/3c", out_valid, out_data); end
    tick();
  endtask

  task automatic test_mask_same_cycle();
    drive(0, 8'h00, 1, 1, 8'hFF);
    tick();
    drive(1, 8'hFF, 1, 1, 8'h00);
    tick();
    drive(1, 8'hFF, 1, 0, 8'h00);
    tick();
    drive(0, 8'h00, 1, 0, 8'h00);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin n_fail++; $display("FAIL same_old_mask got=%b/%h exp=1/00", out_valid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin n_fail++; $display("FAIL same_new_mask got=%b/%h exp=1/ff", out_valid, out_data); end
    drive(0, 8'h00, 1, 1, 8'hFF);
    tick();
  endtask

  task automatic test_backpressure();
    int idx, got;
    for (int i = 1; i <= 2; i++) begin
      drive(1, WIDTH'(i), 0, 0, 8'h00);
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready%0d got=%b exp=1", i, in_ready); end
      tick();
    end
    drive(1, 8'h03, 0, 0, 8'h00);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hFE) begin n_fail++; $display("FAIL bp_held got=%b/%h exp=1/fe", out_valid, out_data); end
    idx = 3;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      drive(idx <= 5, WIDTH'(idx), 1, 0, 8'h00);
      if (c == 0) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      end
      if (out_valid === 1'b1) begin
        n_cmp++; if (out_data !== (8'hFF ^ WIDTH'(got + 1))) begin n_fail++; $display("FAIL bp_order%0d got=%h exp=%h", got, out_data, 8'hFF ^ WIDTH'(got + 1)); end
        got++;
      end
      if (idx <= 5) idx++;
      tick();
    end
    n_cmp++; if (got !== 5) begin n_fail++; $display("FAIL bp_count got=%0d exp=5", got); end
  endtask

  task automatic test_reset_midstream();
    drive(0, 8'h00, 1, 1, 8'h0F);
    tick();
    drive(1, 8'h11, 0, 0, 8'h00);
    tick();
    drive(1, 8'h22, 0, 0, 8'h00);
    tick();
    reset = 1'b1;
    drive(1, 8'h33, 1, 0, 8'h00);
    tick();
    reset = 1'b0;
    drive(0, 8'h00, 1, 0, 8'h00);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    n_cmp++; if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt got=%0d exp=0", xfer_cnt); end
    n_cmp++; if (mask !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_mask got=%h exp=ff", mask); end
    drive(1, 8'h00, 1, 0, 8'h00);
    tick();
    drive(0, 8'h00, 1, 0, 8'h00);
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_word got=%b/%h exp=1/ff", out_valid, out_data); end
    tick();
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    drive(0, 8'h00, 1, 0, 8'h00);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1, WIDTH'(i), 1, 0, 8'h00);
      tick();
    end
    drive(0, 8'h00, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (s_xfer_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap_small_cnt got=%0d exp=1", s_xfer_cnt); end
    n_cmp++; if (xfer_cnt !== 16'd17) begin n_fail++; $display("FAIL wrap_wide_cnt got=%0d exp=17", xfer_cnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, WIDTH'($urandom));
      n_cmp++; if (in_ready !== exp_ir()) begin n_fail++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_ir()); end
      n_cmp++; if (out_valid !== exp_ov()) begin n_fail++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_ov()); end
      if (exp_ov()) begin
        n_cmp++; if (out_data !== q[0].d) begin n_fail++; $display("FAIL rnd_out_data c=%0d got=%h exp=%h", c, out_data, q[0].d); end
        n_cmp++; if (s_out_data !== q[0].d) begin n_fail++; $display("FAIL rnd_small_data c=%0d got=%h exp=%h", c, s_out_data, q[0].d); end
      end
      n_cmp++; if (mask !== mask_m) begin n_fail++; $display("FAIL rnd_mask c=%0d got=%h exp=%h", c, mask, mask_m); end
      n_cmp++; if (xfer_cnt !== 16'(cnt_m)) begin n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, xfer_cnt, cnt_m); end
      n_cmp++; if (s_xfer_cnt !== 4'(cnt_m)) begin n_fail++; $display("FAIL rnd_small_cnt c=%0d got=%0d exp=%0d", c, s_xfer_cnt, cnt_m % 16); end
      tick();
    end
    drive(0, 8'h00, 1, 0, 8'h00);
    for (int i = 0; i < DEPTH + 2; i++) tick();
    n_cmp++; if (out_valid !== 1'b0 || q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got=%b left=%0d exp=0/0", out_valid, q.size()); end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    mask_we   = 1'b0;
    mask_in   = '0;
    cyc       = 0;
    cnt_m     = 0;
    mask_m    = '1;
    @(negedge clk);
    test_reset();
    test_default_mask();
    test_mask_write();
    test_mask_same_cycle();
    test_backpressure();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
